riscv_ex_stage: RTL and testbench
=================================

// Module: riscv_ex_stage
// PURPOSE
//  Execute stage, directly downstream of the ID/EX pipeline register. Consumes its
//  decoded fields, computes the ALU result, load/store address and branch decision,
//  and registers results into the EX/MEM boundary. Contains an optional iterative
//  multiplier that stalls the front end while it runs.
// PARAMETERS
//  XLEN            32  datapath width; must equal width of `RegBus
//  MUL_BITS_PER_CY 1   multiplier bits retired per cycle (1,2,4); STEPS = XLEN/MUL_BITS_PER_CY
// PORTS
//  clk             in   1     clock
//  rst             in   1     reset, asynchronous, active-high
//  valid_i         in   1     ID/EX slot holds a real instruction
//  pc_i            in   `InstAddrBus  instruction PC
//  rd_idx_i        in   `RegAddrBus   destination register
//  rd_we_i         in   1     register write enable
//  alu_op_i        in   `AluOpBus     `ALU_* opcode (riscv_define.v)
//  alu_a_i/alu_b_i in   XLEN  ALU operands; alu_b_i is also store data
//  offset_i        in   XLEN  branch / memory offset
//  br_i            in   1     instruction is a conditional branch
//  zero_en_i       in   1     branch taken when (alu result==0)==zero_en_i
//  data_we_i/re_i  in   1     store / load
//  stall_i         in   1     MEM stage cannot accept; hold EX/MEM
//  stall_o         out  1     front end must hold ID/EX and PC (combinational)
//  br_taken_o      out  1     redirect fetch, flush IF/ID + ID/EX (combinational)
//  br_target_o     out  `InstAddrBus  pc_i + offset_i (combinational)
//  valid_o         out  1     EX/MEM slot valid
//  alu_res_o       out  XLEN  registered ALU / multiply result
//  mem_addr_o      out  XLEN  registered alu_a_i + offset_i
//  st_data_o       out  XLEN  registered alu_b_i
//  rd_idx_o, rd_we_o, data_we_o, data_re_o  out  registered copies of inputs
// BEHAVIOUR
//  - Reset: all registered outputs 0; mul FSM -> IDLE, step counter 0.
//  - ALU ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL/SRL/SRA (shamt=alu_b[4:0]);
//    ALU_NONE and undefined codes -> result 0. Arithmetic modulo 2^XLEN.
//  - stall_o = stall_i | (mul FSM != IDLE) | (valid_i & alu_op_i==`ALU_MUL & state==IDLE).
//  - br_taken_o = valid_i & br_i & ~stall_o & ((res==0)==zero_en_i); never asserted
//    while stalled, so a branch resolves exactly once.
//  - EX/MEM update on posedge: stall_i=1 -> hold all outputs. Else if stall_o due to
//    multiplier -> bubble (valid_o,rd_we_o,data_we_o,data_re_o=0). Else load fields;
//    control bits gated by valid_i (invalid slot -> bubble).
//  - Multiplier FSM (low XLEN bits of product, unsigned==signed):
//    IDLE: valid ALU_MUL seen -> capture a,b, acc=0, cnt=0, -> BUSY.
//    BUSY: acc += a*b[k-bits], shift, cnt++; cnt==STEPS-1 -> DONE.
//    DONE: stall_o=0 (unless stall_i); EX/MEM loads acc with rd fields; -> IDLE.
//    If stall_i high in DONE, remain DONE until it drops. Total stall_o = STEPS+1 cycles.
//  - Back-to-back MUL: second MUL re-enters IDLE->BUSY the cycle after DONE.
//  - rst mid-multiply aborts: FSM IDLE, no result written.
// CONFIGURATION
//  RISCV_EX_MUL_EN defined: multiplier FSM and `ALU_MUL support present.
//  Undefined: no FSM; ALU_MUL treated as ALU_NONE (result 0, single cycle, no stall);
//  stall_o = stall_i.
// TESTING
//  1 ADD a=0x7FFFFFFF b=1 -> alu_res_o=0x80000000 one edge later, valid_o=1.
//  2 SRA a=0x80000000 b=0x24 -> shamt 4, alu_res_o=0xF8000000; SLTU 1,0xFFFFFFFF -> 1.
//  3 SUB branch a=5 b=5 zero_en=1 pc=0x100 off=0x20 -> br_taken_o=1, br_target_o=0x120;
//    same with zero_en=0 -> br_taken_o=0.
//  4 MUL_EN, MUL 0xFFFFFFFF*3 -> stall_o high 33 cycles, bubbles in EX/MEM, then
//    alu_res_o=0xFFFFFFFD with rd_we_o=1.
//  5 stall_i held 3 cycles during DONE -> result held, single valid write when released.
//  6 rst pulsed at BUSY step 10 -> all outputs 0, stall_o=stall_i, next ADD completes normally.

Source files
------------

// File: rtl/riscv_ex_stage.sv
// riscv_ex_stage -- RISC-V execute stage.
//
// Sits directly after the ID/EX pipeline register. Computes the ALU result,
// the load/store address (alu_a_i + offset_i) and the branch decision, and
// registers the results into the EX/MEM boundary.
//
// Optional iterative multiplier, enabled by defining RISCV_EX_MUL_EN.
// - Enabled: ALU_MUL runs for STEPS = XLEN/MUL_BITS_PER_CY cycles in BUSY.
//   stall_o holds the front end for STEPS+1 cycles, and EX/MEM receives
//   bubbles meanwhile.
// - Undefined: ALU_MUL behaves like ALU_NONE, and stall_o is simply stall_i.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   valid_i               ID/EX slot holds a real instruction
//   pc_i, rd_idx_i        instruction PC, destination register
//   rd_we_i               register write enable
//   alu_op_i              `ALU_* opcode
//   alu_a_i, alu_b_i      operands (alu_b_i doubles as store data)
//   offset_i              branch / memory offset
//   br_i, zero_en_i       conditional branch; taken when (res==0)==zero_en_i
//   data_we_i, data_re_i  store / load
//   stall_i               MEM cannot accept: hold EX/MEM
//   stall_o               hold ID/EX and PC (combinational)
//   br_taken_o            redirect fetch and flush (combinational)
//   br_target_o           pc_i + offset_i (combinational)
//   valid_o, alu_res_o, mem_addr_o, st_data_o,
//   rd_idx_o, rd_we_o, data_we_o, data_re_o   registered EX/MEM fields
//   mul_state_o           multiplier FSM state for debug (0 when the FSM is absent)
//
// Handshake: stall_i=1 freezes every EX/MEM output. stall_o=1 means the
// front end must present the same ID/EX contents on the next cycle. A branch
// is only reported taken when stall_o is low, so each branch resolves once.

`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef AluOpBus
`define AluOpBus 3:0
`endif
`ifndef ALU_NONE
`define ALU_NONE 4'd0
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_AND  4'd3
`define ALU_OR   4'd4
`define ALU_XOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_MUL  4'd11
`endif

module riscv_ex_stage #(
  parameter int XLEN            = 32,
  parameter int MUL_BITS_PER_CY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [`InstAddrBus] pc_i,
  input  logic [`RegAddrBus]  rd_idx_i,
  input  logic                rd_we_i,
  input  logic [`AluOpBus]    alu_op_i,
  input  logic [XLEN-1:0]     alu_a_i,
  input  logic [XLEN-1:0]     alu_b_i,
  input  logic [XLEN-1:0]     offset_i,
  input  logic                br_i,
  input  logic                zero_en_i,
  input  logic                data_we_i,
  input  logic                data_re_i,
  input  logic                stall_i,
  output logic                stall_o,
  output logic                br_taken_o,
  output logic [`InstAddrBus] br_target_o,
  output logic                valid_o,
  output logic [XLEN-1:0]     alu_res_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     st_data_o,
  output logic [`RegAddrBus]  rd_idx_o,
  output logic                rd_we_o,
  output logic                data_we_o,
  output logic                data_re_o,
  output logic [1:0]          mul_state_o
);

  localparam int STEPS = XLEN / MUL_BITS_PER_CY;

  // An empty block: elaboration shows the bad configuration by name when
  // MUL_BITS_PER_CY does not evenly divide XLEN.
  if (STEPS * MUL_BITS_PER_CY != XLEN) begin : g_mul_bits_must_divide_xlen
  end

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ex_res;
  logic            mul_stall;   // multiplier owns the slot: bubble EX/MEM
  logic [4:0]      shamt;

  assign shamt = alu_b_i[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      `ALU_ADD:  alu_res = alu_a_i + alu_b_i;
      `ALU_SUB:  alu_res = alu_a_i - alu_b_i;
      `ALU_AND:  alu_res = alu_a_i & alu_b_i;
      `ALU_OR:   alu_res = alu_a_i | alu_b_i;
      `ALU_XOR:  alu_res = alu_a_i ^ alu_b_i;
      `ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a_i) < $signed(alu_b_i)};
      `ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, alu_a_i < alu_b_i};
      `ALU_SLL:  alu_res = alu_a_i << shamt;
      `ALU_SRL:  alu_res = alu_a_i >> shamt;
      `ALU_SRA:  alu_res = $unsigned($signed(alu_a_i) >>> shamt);
      default:   alu_res = '0;
    endcase
  end

`ifdef RISCV_EX_MUL_EN
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  mul_state_t      state, state_nxt;
  logic [XLEN-1:0] mcand, mcand_nxt;    // multiplicand, shifted left each step
  logic [XLEN-1:0] mplier, mplier_nxt;  // multiplier, low bits consumed each step
  logic [XLEN-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [XLEN-1:0] partial;
  logic            mul_start;

  assign mul_start   = valid_i && (alu_op_i == `ALU_MUL) && (state == MUL_IDLE);
  assign mul_stall   = mul_start || (state == MUL_BUSY);
  assign stall_o     = stall_i || mul_stall;
  assign ex_res      = (state == MUL_DONE) ? acc : alu_res;
  assign mul_state_o = state;

  // Partial product of the multiplicand with the next MUL_BITS_PER_CY bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS_PER_CY; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    case (state)
      MUL_IDLE: begin
        if (mul_start) begin
          mcand_nxt  = alu_a_i;
          mplier_nxt = alu_b_i;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        acc_nxt    = acc + partial;
        mcand_nxt  = mcand << MUL_BITS_PER_CY;
        mplier_nxt = mplier >> MUL_BITS_PER_CY;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_W'(STEPS - 1)) state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        // The result leaves on the same edge that EX/MEM accepts it.
        if (!stall_i) state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
    end
  end
`else
  assign mul_stall   = 1'b0;
  assign stall_o     = stall_i;
  assign ex_res      = alu_res;
  assign mul_state_o = 2'd0;
`endif

  assign br_target_o = pc_i + offset_i;
  assign br_taken_o  = valid_i && br_i && !stall_o && ((alu_res == '0) == zero_en_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o    <= 1'b0;
      alu_res_o  <= '0;
      mem_addr_o <= '0;
      st_data_o  <= '0;
      rd_idx_o   <= '0;
      rd_we_o    <= 1'b0;
      data_we_o  <= 1'b0;
      data_re_o  <= 1'b0;
    end else if (!stall_i) begin
      if (mul_stall) begin
        valid_o   <= 1'b0;
        rd_we_o   <= 1'b0;
        data_we_o <= 1'b0;
        data_re_o <= 1'b0;
      end else begin
        valid_o    <= valid_i;
        alu_res_o  <= ex_res;
        mem_addr_o <= alu_a_i + offset_i;
        st_data_o  <= alu_b_i;
        rd_idx_o   <= rd_idx_i;
        rd_we_o    <= valid_i && rd_we_i;
        data_we_o  <= valid_i && data_we_i;
        data_re_o  <= valid_i && data_re_i;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_stage.sv
// tb_riscv_ex_stage -- self-checking bench for riscv_ex_stage.
// The bench covers directed vectors, randomized single-cycle operations
// checked against a reference model, stall and reset sequences, and
// multiplier sequences when RISCV_EX_MUL_EN is defined.

module tb_riscv_ex_stage;

  localparam logic [3:0] OP_NONE = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL = 4'd9,  OP_SRA  = 4'd10, OP_MUL = 4'd11;

`ifdef RISCV_EX_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i, rd_we_i, br_i, zero_en_i, data_we_i, data_re_i, stall_i;
  logic [31:0] pc_i, alu_a_i, alu_b_i, offset_i;
  logic [4:0]  rd_idx_i;
  logic [3:0]  alu_op_i;
  logic        stall_o, br_taken_o, valid_o, rd_we_o, data_we_o, data_re_o;
  logic [31:0] br_target_o, alu_res_o, mem_addr_o, st_data_o;
  logic [4:0]  rd_idx_o;
  logic [1:0]  mul_state_o;

  riscv_ex_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .rd_idx_i(rd_idx_i),
    .rd_we_i(rd_we_i), .alu_op_i(alu_op_i), .alu_a_i(alu_a_i), .alu_b_i(alu_b_i),
    .offset_i(offset_i), .br_i(br_i), .zero_en_i(zero_en_i), .data_we_i(data_we_i),
    .data_re_i(data_re_i), .stall_i(stall_i), .stall_o(stall_o), .br_taken_o(br_taken_o),
    .br_target_o(br_target_o), .valid_o(valid_o), .alu_res_o(alu_res_o),
    .mem_addr_o(mem_addr_o), .st_data_o(st_data_o), .rd_idx_o(rd_idx_o),
    .rd_we_o(rd_we_o), .data_we_o(data_we_o), .data_re_o(data_re_o),
    .mul_state_o(mul_state_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    longint prod;
    sh = int'(b % 32);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 32'($signed(a) >>> sh);
      OP_MUL: begin
        prod = longint'({32'd0, a}) * longint'({32'd0, b});
        return MUL_ON ? 32'(prod) : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pc, off;
    logic        valid, br, zero_en, rd_we, we, re;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input logic br, input logic ze,
                              input logic exp_taken);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_res = exp_res;
    v.br = br; v.zero_en = ze; v.exp_taken = exp_taken;
    v.pc = $urandom; v.off = $urandom; v.valid = 1'b1;
    v.rd = 5'($urandom_range(0, 31)); v.rd_we = 1'b1;
    v.we = 1'($urandom_range(0, 1)); v.re = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    valid_i = v.valid; alu_op_i = v.op; alu_a_i = v.a; alu_b_i = v.b;
    pc_i = v.pc; offset_i = v.off; br_i = v.br; zero_en_i = v.zero_en;
    rd_idx_i = v.rd; rd_we_i = v.rd_we; data_we_i = v.we; data_re_i = v.re;
    stall_i = 1'b0;
  endtask

  task automatic drive_idle();
    valid_i = 0; alu_op_i = OP_NONE; alu_a_i = 0; alu_b_i = 0; pc_i = 0; offset_i = 0;
    br_i = 0; zero_en_i = 0; rd_idx_i = 0; rd_we_i = 0; data_we_i = 0; data_re_i = 0;
    stall_i = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_res"}, alu_res_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_st"}, st_data_o, 0);
    check({tag, "_rd"}, rd_idx_o, 0);
    check({tag, "_rdwe"}, rd_we_o, 0);
    check({tag, "_we"}, data_we_o, 0);
    check({tag, "_re"}, data_re_o, 0);
  endtask

  // Called at posedge+1: drive, check combinational outputs, clock, check EX/MEM.
  task automatic apply_and_check(input vec_t v, input string tag);
    drive(v);
    #1;
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_taken"}, br_taken_o, v.exp_taken);
    check({tag, "_target"}, br_target_o, v.pc + v.off);
    @(posedge clk); #1;
    check({tag, "_res"}, alu_res_o, v.exp_res);
    check({tag, "_valid"}, valid_o, v.valid);
    check({tag, "_rdwe"}, rd_we_o, v.valid & v.rd_we);
    check({tag, "_rd"}, rd_idx_o, v.rd);
    check({tag, "_addr"}, mem_addr_o, v.a + v.off);
    check({tag, "_st"}, st_data_o, v.b);
    check({tag, "_we"}, data_we_o, v.valid & v.we);
    check({tag, "_re"}, data_re_o, v.valid & v.re);
  endtask

  // Holds a MUL in ID/EX until stall_o drops; counts stalled cycles and non-bubbles.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int stall_cycles, output int bubble_bad);
    vec_t v;
    v = mk(OP_MUL, a, b, 32'd0, 1'b0, 1'b0, 1'b0);
    v.rd = rd; v.we = 0; v.re = 0;
    drive(v);
    stall_cycles = 0;
    bubble_bad = 0;
    #1;
    while (stall_o === 1'b1 && stall_cycles < 100) begin
      stall_cycles++;
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || rd_we_o !== 1'b0) bubble_bad++;
    end
  endtask

  // ---------------- test ----------------
  initial begin : main
    vec_t v, v2;
    logic [31:0] a, b, res;
    int sc, bb, hold_bad;

    vecs.push_back(mk(OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 0));
    vecs.push_back(mk(OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 0, 0, 0));
    vecs.push_back(mk(OP_SLTU, 32'h1,         32'hFFFF_FFFF, 32'h1,         0, 0, 0));
    vecs.push_back(mk(OP_SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,         0, 0, 0));
    vecs.push_back(mk(OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0));
    vecs.push_back(mk(OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 0, 0, 0));
    vecs.push_back(mk(OP_SLL,  32'h1,         32'h1F,        32'h8000_0000, 0, 0, 0));
    vecs.push_back(mk(OP_SRL,  32'h8000_0000, 32'h3F,        32'h1,         0, 0, 0));
    vecs.push_back(mk(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0));
    vecs.push_back(mk(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0));
    vecs.push_back(mk(OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0));
    vecs.push_back(mk(OP_NONE, 32'h1234_5678, 32'h9,         32'h0,         0, 0, 0));
    vecs.push_back(mk(4'hF,    32'h1234_5678, 32'h9,         32'h0,         0, 0, 0));
    v = mk(OP_SUB, 32'd5, 32'd5, 32'd0, 1, 1, 1); v.pc = 32'h100; v.off = 32'h20;
    vecs.push_back(v);
    v = mk(OP_SUB, 32'd5, 32'd5, 32'd0, 1, 0, 0); v.pc = 32'h100; v.off = 32'h20;
    vecs.push_back(v);
    v = mk(OP_SUB, 32'd5, 32'd5, 32'd0, 1, 1, 0); v.valid = 0;
    vecs.push_back(v);
    if (!MUL_ON) vecs.push_back(mk(OP_MUL, 32'd6, 32'd7, 32'd0, 0, 0, 0));

    // Reset: outputs zero even with a live instruction presented.
    rst = 1'b1;
    drive(mk(OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_stall", stall_o, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_and_check(vecs[i], $sformatf("vec%0d", i));

    // Randomized single-cycle operations against the model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (MUL_ON && op == OP_MUL) op = OP_ADD;
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      res = ref_alu(op, a, b);
      v = mk(op, a, b, res, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      v.valid = ($urandom_range(0, 5) != 0);
      v.rd_we = 1'($urandom_range(0, 1));
      v.exp_taken = v.valid && v.br && ((res == 0) == v.zero_en);
      apply_and_check(v, $sformatf("rnd%0d", i));
    end

    // stall_i holds EX/MEM and suppresses a ready branch until released.
    v = mk(OP_ADD, 32'd10, 32'd20, 32'd30, 0, 0, 0); v.rd = 5'd3;
    apply_and_check(v, "pre_stall");
    v2 = mk(OP_SUB, 32'd5, 32'd5, 32'd0, 1, 1, 1); v2.rd = 5'd7;
    drive(v2);
    stall_i = 1'b1;
    #1;
    check("stall_o_follows", stall_o, 1);
    check("stall_no_taken", br_taken_o, 0);
    hold_bad = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (alu_res_o !== 32'd30 || valid_o !== 1'b1 || rd_idx_o !== 5'd3) hold_bad++;
    end
    check("stall_hold", hold_bad, 0);
    stall_i = 1'b0;
    #1;
    check("release_taken", br_taken_o, 1);
    @(posedge clk); #1;
    check("release_res", alu_res_o, 0);
    check("release_rd", rd_idx_o, 5'd7);

    // Reset in the middle of traffic, then normal operation.
    apply_and_check(mk(OP_XOR, 32'hAAAA_5555, 32'h1, 32'hAAAA_5554, 0, 0, 0), "pre_rst");
    drive_idle();
    rst = 1'b1; #2;
    check_zero("midrst");
    rst = 1'b0; #1;
    check("midrst_stall", stall_o, 0);
    @(posedge clk); #1;
    apply_and_check(mk(OP_ADD, 32'd100, 32'd23, 32'd123, 0, 0, 0), "post_rst");

`ifdef RISCV_EX_MUL_EN
    // MUL 0xFFFFFFFF * 3, followed by a back-to-back MUL.
    run_mul(32'hFFFF_FFFF, 32'd3, 5'd9, sc, bb);
    check("mul_stall_cycles", sc, 33);
    check("mul_bubbles", bb, 0);
    check("mul_done_taken", br_taken_o, 0);
    @(posedge clk); #1;
    check("mul_res", alu_res_o, 32'hFFFF_FFFD);
    check("mul_valid", valid_o, 1);
    check("mul_rdwe", rd_we_o, 1);
    check("mul_rd", rd_idx_o, 5'd9);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_mul(a, b, 5'(i + 1), sc, bb);
      check($sformatf("b2b%0d_stall_cycles", i), sc, 33);
      check($sformatf("b2b%0d_bubbles", i), bb, 0);
      @(posedge clk); #1;
      check($sformatf("b2b%0d_res", i), alu_res_o, ref_alu(OP_MUL, a, b));
      check($sformatf("b2b%0d_valid", i), valid_o, 1);
    end
    drive_idle();
    @(posedge clk); #1;
    check("after_mul_idle_valid", valid_o, 0);

    // stall_i held for 3 cycles while the product waits.
    a = $urandom; b = $urandom;
    run_mul(a, b, 5'd17, sc, bb);
    check("donehold_stall_cycles", sc, 33);
    stall_i = 1'b1;
    #1;
    check("donehold_stall_o", stall_o, 1);
    hold_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || rd_we_o !== 1'b0 || stall_o !== 1'b1) hold_bad++;
    end
    check("donehold_held", hold_bad, 0);
    stall_i = 1'b0;
    #1;
    check("donehold_release_stall", stall_o, 0);
    @(posedge clk); #1;
    check("donehold_res", alu_res_o, ref_alu(OP_MUL, a, b));
    check("donehold_valid", valid_o, 1);
    check("donehold_rd", rd_idx_o, 5'd17);
    drive_idle();
    @(posedge clk); #1;
    check("donehold_single_write", valid_o, 0);

    // Reset during BUSY step 10 aborts the multiply.
    v = mk(OP_MUL, 32'd1000, 32'd1000, 32'd0, 0, 0, 0);
    drive(v);
    repeat (11) @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1; #2;
    check_zero("mulrst");
    rst = 1'b0; #1;
    check("mulrst_stall", stall_o, 0);
    @(posedge clk); #1;
    check("mulrst_no_result", valid_o, 0);
    apply_and_check(mk(OP_ADD, 32'd7, 32'd8, 32'd15, 0, 0, 0), "mulrst_add");
    run_mul(32'd6, 32'd7, 5'd4, sc, bb);
    check("mulrst_mul_cycles", sc, 33);
    @(posedge clk); #1;
    check("mulrst_mul_res", alu_res_o, 32'd42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
